// File: rtl/adc_lvds_capture.sv
// adc_lvds_capture
//   Conversion sequencer and deserializer for the eight-lane LVDS ADC front
//   end. It strobes CNV_n, waits out the conversion time, clocks SAMPLE_BITS
//   SCK periods while shifting in every SDO lane MSB first, then writes one
//   packed word per conversion into the acquisition FIFO.
//
//   Optional build macro: ADC_TEST_PATTERN_EN. When it is defined and
//   i_debug_en is high at push time, lane k carries {k[3:0], index[11:0]}
//   instead of captured data.
//
// Ports
//   clk, rst_n        MIG ui clock; synchronous active-low reset
//   i_start           one-cycle start pulse; accepted only in idle with i_calib_done
//   i_samples_count   conversions per run, latched at start
//   i_calib_done      DDR3 calibration complete
//   i_debug_en        test-pattern select (pattern build only)
//   i_fifo_full       FIFO full; sampled only at push time
//   o_ADC_CNV_n       convert strobe, active low, 4 identical bits
//   o_ADC_SCK         serial clock, 4 identical bits
//   i_ADC_SDO         serial data, one bit per lane
//   o_data            packed word, lane k at [SB*k +: SB]
//   o_rdy             one-cycle FIFO write enable, aligned with o_data
//   o_busy            high from accepted start until finish
//   o_finished        one-cycle end-of-run pulse
//   o_overflow        sticky: a word was dropped because the FIFO was full

// Per-lane MSB-first shift register.
module adc_lvds_lane #(
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_shift,
  input  logic                   i_sdo,
  output logic [SAMPLE_BITS-1:0] o_sr
);
  logic [SAMPLE_BITS-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (!rst_n)       r_sr <= '0;
    else if (i_shift) r_sr <= {r_sr[SAMPLE_BITS-2:0], i_sdo};
  end

  assign o_sr = r_sr;
endmodule

module adc_lvds_capture #(
  parameter int N_LANES     = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int SCK_DIV     = 2,
  parameter int T_CNV       = 4,
  parameter int T_CONV      = 60
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic [31:0]                    i_samples_count,
  input  logic                           i_calib_done,
  input  logic                           i_debug_en,
  input  logic                           i_fifo_full,
  output logic [3:0]                     o_ADC_CNV_n,
  output logic [3:0]                     o_ADC_SCK,
  input  logic [N_LANES-1:0]             i_ADC_SDO,
  output logic [N_LANES*SAMPLE_BITS-1:0] o_data,
  output logic                           o_rdy,
  output logic                           o_busy,
  output logic                           o_finished,
  output logic                           o_overflow
);
  localparam int BW = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
  localparam logic [31:0]   CNV_LAST  = 32'(T_CNV - 1);
  localparam logic [31:0]   CONV_LAST = 32'(T_CONV - 1);
  localparam logic [31:0]   HALF_LAST = 32'(SCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SAMPLE_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CNV, S_WAIT, S_SHIFT, S_PUSH, S_DONE} state_t;

  state_t r_state, w_next;

  logic        r_cnv_n, r_sck, r_rdy, r_busy, r_fin, r_ovf;
  logic [31:0] r_cnt;        // cycles in CNV/WAIT, half-period cycles in SHIFT
  logic [BW-1:0] r_bit;      // falling SCK edges seen in this conversion
  logic [31:0] r_remaining;
  logic [31:0] r_idx;
  logic [N_LANES-1:0][SAMPLE_BITS-1:0] r_data, w_sr, w_word;

  logic w_accept, w_half_end, w_fall;

  assign w_accept   = i_start && i_calib_done;
  assign w_half_end = (r_cnt == HALF_LAST);
  // The edge that takes SCK high->low is also the SDO sampling edge.
  assign w_fall     = (r_state == S_SHIFT) && r_sck && w_half_end;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (i_samples_count == 32'd0) ? S_DONE : S_CNV;
      S_CNV:   if (r_cnt == CNV_LAST)  w_next = S_WAIT;
      S_WAIT:  if (r_cnt == CONV_LAST) w_next = S_SHIFT;
      S_SHIFT: if (w_fall && (r_bit == BIT_LAST)) w_next = S_PUSH;
      S_PUSH:  w_next = (r_remaining <= 32'd1) ? S_DONE : S_CNV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Lane shift registers and push-word selection
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    adc_lvds_lane #(.SAMPLE_BITS(SAMPLE_BITS)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_shift (w_fall),
      .i_sdo   (i_ADC_SDO[k]),
      .o_sr    (w_sr[k])
    );
`ifdef ADC_TEST_PATTERN_EN
    localparam logic [3:0] LANE_ID = 4'(k);
    assign w_word[k] = i_debug_en ? SAMPLE_BITS'({LANE_ID, r_idx[11:0]}) : w_sr[k];
`else
    assign w_word[k] = w_sr[k];
`endif
  end

`ifndef ADC_TEST_PATTERN_EN
  logic w_unused_dbg;
  assign w_unused_dbg = i_debug_en;
`endif

  // Datapath; pad outputs are registered off the next state so they line
  // up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnv_n     <= 1'b1;
      r_sck       <= 1'b0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
      r_fin       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnv_n <= (w_next != S_CNV);
      r_rdy   <= 1'b0;
      r_fin   <= 1'b0;

      if ((w_next != r_state) || ((r_state == S_SHIFT) && w_half_end))
        r_cnt <= '0;
      else if (r_state inside {S_CNV, S_WAIT, S_SHIFT})
        r_cnt <= r_cnt + 32'd1;

      case (r_state)
        S_IDLE: if (w_accept) begin
          r_remaining <= i_samples_count;
          r_idx       <= '0;
          r_ovf       <= 1'b0;
          r_busy      <= 1'b1;
        end
        S_WAIT: begin
          r_bit <= '0;
          r_sck <= 1'b0;
        end
        S_SHIFT: begin
          if (w_half_end) r_sck <= ~r_sck;
          if (w_fall)     r_bit <= r_bit + BW'(1);
        end
        S_PUSH: begin
          if (!i_fifo_full) begin
            r_data <= w_word;
            r_rdy  <= 1'b1;
          end else begin
            r_ovf  <= 1'b1;
          end
          if (r_remaining != 32'd0) r_remaining <= r_remaining - 32'd1;
          r_idx <= r_idx + 32'd1;
        end
        S_DONE: begin
          r_busy <= 1'b0;
          r_fin  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ADC_CNV_n = {4{r_cnv_n}};
  assign o_ADC_SCK   = {4{r_sck}};
  assign o_data      = r_data;
  assign o_rdy       = r_rdy;
  assign o_busy      = r_busy;
  assign o_finished  = r_fin;
  assign o_overflow  = r_ovf;
endmodule

// File: tb/tb_adc_lvds_capture.sv
// Scoreboard bench for adc_lvds_capture. An ADC model serves per-conversion
// sample words on SDO; expected words and arrival cycles are derived from the
// conversion period arithmetic and queued when each run is started, and a
// monitor pops and compares on every o_rdy / o_finished.
module tb_adc_lvds_capture;
  localparam int N = 8, SB = 16, SCK_DIV = 2, T_CNV = 4, T_CONV = 60;
  localparam int P  = T_CNV + T_CONV + 2*SCK_DIV*SB + 1;
  localparam int DW = N*SB;

  logic clk = 0, rst_n = 0, i_start = 0, i_calib_done = 0, i_debug_en = 0, i_fifo_full = 0;
  logic [31:0]   i_samples_count = 0;
  logic [3:0]    o_ADC_CNV_n, o_ADC_SCK;
  logic [N-1:0]  i_ADC_SDO = '0;
  logic [DW-1:0] o_data;
  logic          o_rdy, o_busy, o_finished, o_overflow;

  adc_lvds_capture #(.N_LANES(N), .SAMPLE_BITS(SB), .SCK_DIV(SCK_DIV), .T_CNV(T_CNV), .T_CONV(T_CONV)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_samples_count(i_samples_count),
    .i_calib_done(i_calib_done), .i_debug_en(i_debug_en), .i_fifo_full(i_fifo_full),
    .o_ADC_CNV_n(o_ADC_CNV_n), .o_ADC_SCK(o_ADC_SCK), .i_ADC_SDO(i_ADC_SDO),
    .o_data(o_data), .o_rdy(o_rdy), .o_busy(o_busy), .o_finished(o_finished), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ADC model: new conversion on CNV_n fall, next bit after each SCK fall.
  logic [15:0] conv_words [64][N];
  int adc_conv = -1, adc_bit = 0;
  logic prev_cnv = 1'b1, prev_sck = 1'b0;
  always @(negedge clk) begin
    if (prev_cnv && !o_ADC_CNV_n[0]) begin adc_conv++; adc_bit = 0; end
    else if (prev_sck && !o_ADC_SCK[0]) adc_bit++;
    prev_cnv = o_ADC_CNV_n[0];
    prev_sck = o_ADC_SCK[0];
    for (int k = 0; k < N; k++)
      i_ADC_SDO[k] = (adc_conv >= 0 && adc_conv < 64 && adc_bit < SB) ?
                     conv_words[adc_conv][k][SB-1-adc_bit] : 1'b0;
  end

  // Scoreboard
  typedef struct { logic [DW-1:0] data; int unsigned at; } exp_t;
  exp_t        rdy_q[$];
  int unsigned fin_q[$];
  exp_t        e;
  int unsigned fe;

  always @(negedge clk) begin
    if (o_rdy) begin
      if (rdy_q.size() == 0) chk("unexpected_rdy", 1, 0);
      else begin
        e = rdy_q.pop_front();
        chk("rdy_data", o_data, e.data);
        chk("rdy_cycle", DW'(cyc), DW'(e.at));
      end
    end
    if (o_finished) begin
      if (fin_q.size() == 0) chk("unexpected_finished", 1, 0);
      else begin
        fe = fin_q.pop_front();
        chk("finished_cycle", DW'(cyc), DW'(fe));
      end
    end
  end

  function automatic logic [DW-1:0] exp_word(input int i, input bit pat);
    logic [DW-1:0] w;
    for (int k = 0; k < N; k++)
      w[16*k +: 16] = pat ? 16'((k << 12) | (i & 'hFFF)) : conv_words[i][k];
    return w;
  endfunction

  // One run: n conversions, conversion full_conv (if >= 0) sees a full FIFO.
  task automatic run(input int n, input bit rnd, input int full_conv, input bit second, input bit pat);
    int unsigned c, last;
    bit cnv_seen = 0, any_push = 0;
    logic [DW-1:0] lastw = '0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < N; k++)
        conv_words[i][k] = rnd ? 16'($urandom) : 16'hA5A0 + 16'(k);
    adc_conv = -1;
    i_debug_en = pat;
    i_samples_count = n;
    i_start = 1;
    c = cyc;
    for (int i = 0; i < n; i++)
      if (i != full_conv) begin
        lastw = exp_word(i, pat);
        any_push = 1;
        rdy_q.push_back('{lastw, c + 1 + P*(i+1)});
      end
    last = (n == 0) ? 2 : P*n + 2;
    fin_q.push_back(c + last);
    for (int m = 1; m <= int'(last) + 3; m++) begin
      @(negedge clk);
      i_start = second && m == 200;
      if (m == 200) i_samples_count = 7;
      i_fifo_full = full_conv >= 0 && m > P*full_conv && m <= P*(full_conv+1);
      if (!o_ADC_CNV_n[0]) cnv_seen = 1;
      if (m == 1) begin
        chk("ovf_cleared_at_start", o_overflow, 0);
        chk("busy_on", o_busy, 1);
        if (n > 0) chk("cnv_latency", o_ADC_CNV_n, 4'h0);
      end
    end
    i_fifo_full = 0;
    chk("busy_off", o_busy, 0);
    chk("rdy_q_drained", rdy_q.size(), 0);
    chk("fin_q_drained", fin_q.size(), 0);
    chk("cnv_idle", o_ADC_CNV_n, 4'hF);
    if (n == 0) chk("no_cnv_activity", cnv_seen, 0);
    if (any_push) chk("data_hold", o_data, lastw);
    chk("overflow_flag", o_overflow, (full_conv >= 0 && full_conv < n) ? 1 : 0);
  endtask

  initial begin
    int n, fc;
    bit busy_seen, cnv_seen;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_cnv_n", o_ADC_CNV_n, 4'hF);
    chk("rst_sck", o_ADC_SCK, 0);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_finished", o_finished, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_data", o_data, 0);
    rst_n = 1;
    i_calib_done = 1;
    repeat (2) @(negedge clk);

    run(3, 0, -1, 1, 0);           // fixed pattern with an ignored second start
    run(0, 0, -1, 0, 0);           // zero count

    // Start without calibration: no response at all.
    i_calib_done = 0;
    i_samples_count = 2;
    i_start = 1;
    busy_seen = 0; cnv_seen = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      i_start = 0;
      if (o_busy) busy_seen = 1;
      if (!o_ADC_CNV_n[0]) cnv_seen = 1;
    end
    chk("nocal_busy", busy_seen, 0);
    chk("nocal_cnv", cnv_seen, 0);
    i_calib_done = 1;

    run(3, 1, 1, 0, 0);            // overflow on the 2nd push
    for (int r = 0; r < 3; r++) begin
      n  = $urandom_range(1, 4);
      fc = $urandom_range(0, n);
      run(n, 1, (fc == n) ? -1 : fc, 0, 0);
    end

    // Mid-run reset during the first SHIFT.
    adc_conv = -1;
    i_samples_count = 3;
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    for (int t = 0; t < 200 && !o_ADC_SCK[0]; t++) @(negedge clk);
    chk("reach_shift", o_ADC_SCK[0], 1);
    rst_n = 0;
    @(negedge clk);
    chk("abort_cnv_n", o_ADC_CNV_n, 4'hF);
    chk("abort_sck", o_ADC_SCK, 0);
    chk("abort_busy", o_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (300) @(negedge clk);
    chk("post_abort_busy", o_busy, 0);
    chk("post_abort_cnv", o_ADC_CNV_n, 4'hF);
    run(1, 1, -1, 0, 0);           // back in idle and fully functional

`ifdef ADC_TEST_PATTERN_EN
    run(3, 1, -1, 0, 1);
    chk("pattern_lane3", o_data[63:48], 16'h3002);
    chk("pattern_lane0", o_data[15:0], 16'h0002);
    i_debug_en = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
